// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: divider FSM states,
// divider latency helper and MDU operation encodings.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    typedef enum logic [2:0] {
        MDU_NONE,
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU,
        MDU_MFHI,
        MDU_MFLO
    } mdu_op_t;

    // Cycles from start to done for a given operand width.
    function automatic int div_lat(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitude
// and for restoring the sign of quotient and remainder.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle.
// Signed support is built only when DIV_SIGNED_EN is defined.
module div_iter_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic             dd_neg, dv_neg;
    logic [WIDTH-1:0] abs_dd, abs_dv;
    logic [WIDTH-1:0] qfix, rfix;
    logic [WIDTH:0]   shl, diff;

`ifdef DIV_SIGNED_EN
    assign dd_neg = signed_div & dividend[WIDTH-1];
    assign dv_neg = signed_div & divisor[WIDTH-1];

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dd (
        .neg (dd_neg),
        .a   (dividend),
        .y   (abs_dd)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dv (
        .neg (dv_neg),
        .a   (divisor),
        .y   (abs_dv)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .neg (qneg_q),
        .a   (quo_q),
        .y   (qfix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .neg (rneg_q),
        .a   (rem_q),
        .y   (rfix)
    );
`else
    logic unused_sign;

    assign dd_neg      = 1'b0;
    assign dv_neg      = 1'b0;
    assign abs_dd      = dividend;
    assign abs_dv      = divisor;
    assign qfix        = quo_q;
    assign rfix        = rem_q;
    assign unused_sign = signed_div ^ qneg_q ^ rneg_q;
`endif

    assign shl  = {rem_q, quo_q[WIDTH-1]};
    assign diff = shl - {1'b0, dvs_q};

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        stall       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall = start & ~cancel;
            end
            RUN: begin
                stall = 1'b1;
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shl[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                stall       = 1'b1;
                quotient_d  = qfix;
                remainder_d = rfix;
                div_zero_d  = dz_q;
                state_d     = DONE;
            end
            DONE: begin
                done    = ~cancel;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new divide may be accepted from IDLE or straight out of DONE.
        if (start && (state_q == IDLE || state_q == DONE)) begin
            rem_d   = '0;
            quo_d   = abs_dd;
            dvs_d   = abs_dv;
            qneg_d  = dd_neg ^ dv_neg;
            rneg_d  = dd_neg;
            dz_d    = (divisor == '0);
            cnt_d   = '0;
            state_d = RUN;
        end

        if (cancel) begin
            state_d     = IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = div_zero_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit (WIDTH=32): vector table,
// hand-written timing sequences and randomized reference checks.
module tb_div_iter_unit;

`ifdef DIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stall      (stall),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sd;
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics from plain arithmetic.
    task automatic ref_div(input bit sd, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] q,
                           output logic [31:0] r, output bit z);
        bit     se;
        longint sa, sb;
        se = sd & SEN;
        z  = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            if (se && a[31]) q = 32'd1;
            r = a;
        end else if (se) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one divide and wait (bounded) for done.
    task automatic run_div(input bit sd, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] q,
                           output logic [31:0] r, output logic z,
                           output int lat, output int stl);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        #1;
        lat = -1;
        q   = 'x;
        r   = 'x;
        z   = 1'bx;
        stl = stall ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            #1;
            if (done) begin
                lat = k;
                q   = quotient;
                r   = remainder;
                z   = div_zero;
                break;
            end
            if (stall) stl++;
        end
    endtask

    initial begin
        logic [31:0] q, r, eq, er;
        logic        z;
        bit          ez;
        int          lat, stl, first_done;

        tbl[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
        tbl[1] = '{1, 32'hFFFF_FFF9, 32'd2,
                   SEN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                   SEN ? 32'hFFFF_FFFF : 32'd1, 0};
        tbl[2] = '{1, 32'd7, 32'hFFFF_FFFE,
                   SEN ? 32'hFFFF_FFFD : 32'd0,
                   SEN ? 32'd1 : 32'd7, 0};
        tbl[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF,
                   SEN ? 32'h8000_0000 : 32'd0,
                   SEN ? 32'd0 : 32'h8000_0000, 0};
        tbl[4] = '{0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1};
        tbl[5] = '{0, 32'd9, 32'd3, 32'd3, 32'd0, 0};
        tbl[6] = '{1, 32'hFFFF_FFF9, 32'd0,
                   SEN ? 32'd1 : 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1};
        tbl[7] = '{0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0};
        tbl[8] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 0};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dz", div_zero, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table; latency and stall window on every entry.
        foreach (tbl[i]) begin
            run_div(tbl[i].sd, tbl[i].dd, tbl[i].dv, q, r, z, lat, stl);
            chk($sformatf("tbl%0d_lat", i), lat, 34);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), z, tbl[i].dz);
            if (i == 0) chk("tbl0_stall_cycles", stl, 34);
            @(negedge clk);
            #1;
            chk($sformatf("tbl%0d_done_pulse", i), done, 0);
        end

        // Cancel mid-run: 20/3 aborted at cycle 10.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0;
        dividend = 32'd20; divisor = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_stall", stall, 0);
        first_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) first_done = 1;
        end
        chk("cancel_no_done", first_done, 0);
        chk("cancel_keep_q", quotient, 32'd1);
        chk("cancel_keep_r", remainder, 32'd0);
        run_div(0, 32'd9, 32'd3, q, r, z, lat, stl);
        chk("after_cancel_q", q, 32'd3);
        chk("after_cancel_r", r, 32'd0);
        chk("after_cancel_lat", lat, 34);

        // Back-to-back with a start pulse during RUN ignored.
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        first_done = -1;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 34) begin
                #1;
                chk("b2b_done1", done, 1);
                chk("b2b_q1", quotient, 32'd10);
                chk("b2b_r1", remainder, 32'd0);
                start = 1'b1; dividend = 32'd8; divisor = 32'd3;
            end
            if (k == 40) begin
                start = 1'b1; dividend = 32'd99; divisor = 32'd1;
            end
            #1;
            if (k > 34 && done && first_done < 0) begin
                first_done = k;
                q = quotient;
                r = remainder;
            end
        end
        chk("b2b_done2_cycle", first_done, 68);
        chk("b2b_q2", q, 32'd2);
        chk("b2b_r2", r, 32'd2);

        // Reset mid-operation clears outputs and returns to IDLE.
        @(negedge clk);
        start = 1'b1; dividend = 32'd77; divisor = 32'd4;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_done", done, 0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b;
            bit          sd;
            int          sel;
            sd  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel < 4) b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = -32'($urandom_range(1, 15));
            else b = $urandom;
            ref_div(sd, a, b, eq, er, ez);
            run_div(sd, a, b, q, r, z, lat, stl);
            chk($sformatf("rnd%0d_lat", n), lat, 34);
            chk($sformatf("rnd%0d_q %0h/%0h", n, a, b), q, eq);
            chk($sformatf("rnd%0d_r %0h/%0h", n, a, b), r, er);
            chk($sformatf("rnd%0d_dz", n), z, ez);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised iterative restoring divider for the execute stage of the MIPS pipeline; it implements DIV/DIVU and produces quotient and remainder for the HI/LO write path. One quotient bit is resolved per cycle, and the unit asserts a stall toward the hazard logic until the result is ready. It replaces single-cycle combinational division and sits beside the ALU, driven from the decoded E-stage control.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived)

Ports:
- clk  in  1  clock; every register updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a divide using the operands present this cycle
- signed_div  in  1  1 = DIV (signed), 0 = DIVU
- dividend  in  WIDTH  numerator (rs)
- divisor  in  WIDTH  denominator (rt)
- cancel  in  1  abort, driven from flushE
- stall  out  1  hold the pipeline; combinational
- done  out  1  result valid this cycle; one-cycle pulse
- quotient  out  WIDTH  to LO
- remainder  out  WIDTH  to HI
- div_zero  out  1  last completed divide had divisor == 0

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1:
  - Latch |dividend| and |divisor|, the quotient sign (sign(dd) XOR sign(dv)) and the remainder sign (sign(dd)).
  - Clear the counter and go to RUN.
  - When signed_div=0, treat operands as unsigned.
- RUN, each cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quo LSB = 1.
  - Increment the counter. After WIDTH iterations, go to FIX.
- FIX:
  - Negate quo if the quotient sign is set; negate rem if the remainder sign is set. All arithmetic wraps mod 2^WIDTH.
  - Register the results into quotient/remainder and go to DONE.
- DONE:
  - done=1.
  - start=1 begins a new divide (go to RUN with fresh operands); otherwise go to IDLE.
- Outputs hold their value until the next completed divide.
- Divide by zero: quotient = all ones (unsigned view, before sign fix), remainder = dividend, div_zero=1. There is no trap.
- Signed overflow, −2^(WIDTH−1) / −1: quotient = −2^(WIDTH−1), remainder = 0, no flag.
- Signed rounding truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
- cancel=1 in any state:
  - Go to IDLE next cycle. done is not raised; quotient, remainder and div_zero keep their old values.
  - cancel overrides start in the same cycle.
- start while in RUN or FIX is ignored.

## Timing
- Reset: state=IDLE; quotient, remainder, div_zero, done, counter and internal registers all 0; stall=0.
- Latency: start sampled in cycle 0, done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- stall = (start & IDLE & ~cancel) | RUN | FIX. Consequences:
  - The issuing instruction is held in E from cycle 0 through cycle WIDTH+1.
  - stall=0 in DONE, so the instruction advances while done=1 and the HI/LO write is captured in M.
- Back-to-back: start in DONE gives the next done WIDTH+2 cycles later, with no IDLE bubble.
- Reset mid-operation behaves exactly like cancel and also clears the outputs.

## Configuration
- DIV_SIGNED_EN defined: signed_div is honoured; abs/negate logic and the sign flags are built.
- DIV_SIGNED_EN undefined:
  - signed_div is ignored and every divide is unsigned.
  - FIX is a plain register transfer; latency stays WIDTH+2 so pipeline timing does not change.

## Structure
- Shared package mdu_pkg:
  - div_state_t enum (IDLE, RUN, FIX, DONE)
  - DIV_LAT = WIDTH+2 helper function
  - MDU op encodings used by the controller
- Sub-module div_sign_fix (combinational, WIDTH-parametrised): conditional two's-complement negate. Instantiated for operand abs and for the result fix.

## Test plan
- DIVU 100 / 7, WIDTH=32 → done at cycle 34; quotient=14, remainder=2, div_zero=0; stall high cycles 0–33.
- DIV −7 / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1); DIV 7 / −2 → −3, 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; DIVU 5 / 0 → quotient=0xFFFFFFFF, remainder=5, div_zero=1.
- Start 20 / 3, cancel at cycle 10 → IDLE at cycle 11, no done, previous outputs retained; a new start 9 / 3 yields 3, 0.
- Back-to-back: start 50 / 5, then assert start again in DONE with 8 / 3 → done at cycles 34 and 68, results 10/0 then 2/2. start pulsed during RUN is ignored.
- WIDTH=8, DIV_SIGNED_EN undefined: signed_div=1, 0xF0 / 0x10 → quotient=0x0F, remainder=0, done at cycle 10.
